// File: rtl/text_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : text_fetch_scheduler
// Purpose  : Arbitrates the single-port text VRAM of the VGA console between
//            the display line fetch and a write requester.  In the first
//            horizontal-blanking pixel before each new character row the
//            block bursts that row's COLS words from VRAM into the line
//            buffer.  In every other cycle the VRAM port belongs to the
//            writer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   pix_clk    in   1       pixel clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   H_count    in   12      horizontal position from the sync generator
//   V_count    in   12      vertical position from the sync generator
//   wr_valid   in   1       writer request (held until granted)
//   wr_addr    in   ADDR_W  writer VRAM address
//   wr_data    in   DATA_W  writer data
//   wr_ready   out  1       writer grant (combinational, low during FETCH)
//   ram_en     out  1       VRAM access enable
//   ram_we     out  1       VRAM write enable
//   ram_addr   out  ADDR_W  VRAM address
//   ram_wdata  out  DATA_W  VRAM write data
//   ram_rdata  in   DATA_W  VRAM read data, one cycle after a read
//   lb_we      out  1       line-buffer write strobe
//   lb_addr    out  LB_AW   line-buffer column
//   lb_data    out  DATA_W  line-buffer data
//   busy       out  1       a burst is in progress (state != IDLE)
//   overrun    out  1       sticky: a fetch trigger arrived during FETCH
// ============================================================================
module text_fetch_scheduler #(
   parameter int COLS           = 80,
   parameter int CHAR_H         = 16,
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 16,
   parameter int LB_AW          = 7,
   parameter int H_FETCH        = 640,
   parameter int V_ACTIVE_LINES = 480,
   parameter int V_TOTAL        = 525
) (
   input  logic              pix_clk,
   input  logic              rst,
   input  logic [11:0]       H_count,
   input  logic [11:0]       V_count,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              lb_we,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_data,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Timing constants brought to the width of the sync counters so every
   // comparison is made at 12 bits.
   localparam logic [11:0]       H_TRIG    = 12'(H_FETCH);
   localparam logic [11:0]       V_LAST    = 12'(V_TOTAL - 1);
   localparam logic [11:0]       V_ACT     = 12'(V_ACTIVE_LINES);
   // CHAR_H is a power of two, so "line mod CHAR_H" is a mask and
   // "line / CHAR_H" is a shift.
   localparam logic [11:0]       LINE_MASK = 12'(CHAR_H - 1);
   localparam int                ROW_SH    = $clog2(CHAR_H);
   localparam logic [LB_AW-1:0]  LAST_IDX  = LB_AW'(COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

   state_t            state;
   state_t            state_nxt;
   logic [LB_AW-1:0]  idx;
   logic [LB_AW-1:0]  idx_nxt;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] base_nxt;
   logic              set_overrun;

   logic [11:0]       next_line;
   logic [11:0]       text_row;
   logic              trigger;
   logic [ADDR_W-1:0] trig_base;

   // ------------------------------------------------------------------------
   // Fetch trigger: the line about to be displayed is the first scan line of
   // a character row inside the active area, and the beam has just entered
   // horizontal blanking.
   // ------------------------------------------------------------------------
   always_comb begin
      next_line = (V_count == V_LAST) ? 12'd0 : V_count + 12'd1;
      text_row  = next_line >> ROW_SH;
      trigger   = (H_count == H_TRIG) &&
                  (next_line < V_ACT) &&
                  ((next_line & LINE_MASK) == 12'd0);
      trig_base = ADDR_W'(text_row) * COLS_A;
   end

   // ------------------------------------------------------------------------
   // Burst sequencer: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      base_nxt    = base;
      set_overrun = 1'b0;

      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt = FETCH;
               base_nxt  = trig_base;
               idx_nxt   = '0;
            end
         end

         FETCH: begin
            idx_nxt = idx + LB_AW'(1);
            if (idx == LAST_IDX) begin
               state_nxt = DRAIN;
            end
            // A trigger here means the previous burst could not finish in
            // time; flag it and let the current burst run to completion.
            if (trigger) begin
               set_overrun = 1'b1;
            end
         end

         DRAIN: begin
            // The final read's data lands in this cycle through the line
            // buffer pipeline, so a new burst may already start issuing.
            if (trigger) begin
               state_nxt = FETCH;
               base_nxt  = trig_base;
               idx_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // VRAM port mux: the fetch owns the port during FETCH, the writer at all
   // other times.  Unused address/data are parked at zero.
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ready  = (state != FETCH);
      busy      = (state != IDLE);
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      if (state == FETCH) begin
         ram_en   = 1'b1;
         ram_addr = base + ADDR_W'(idx);
      end else if (wr_valid) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end
   end

   // Read data is only meaningful while the strobe is up; keep the bus
   // quiet otherwise.
   always_comb begin
      lb_data = lb_we ? ram_rdata : '0;
   end

   // ------------------------------------------------------------------------
   // State, sticky overrun flag and the line-buffer pipeline stage.  The
   // pipeline follows the read issue by one cycle regardless of the state,
   // so the last word of a burst is written during DRAIN (or a new FETCH).
   // ------------------------------------------------------------------------
   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         base    <= '0;
         overrun <= 1'b0;
         lb_we   <= 1'b0;
         lb_addr <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         base  <= base_nxt;
         if (set_overrun) begin
            overrun <= 1'b1;
         end
         lb_we <= (state == FETCH);
         if (state == FETCH) begin
            lb_addr <= idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_text_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_fetch_scheduler
// Purpose  : Self-checking bench for text_fetch_scheduler.  A behavioural
//            VRAM model answers the DUT's port; a reference copy of the
//            VRAM contents plus the row/base arithmetic of the console
//            decides every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_fetch_scheduler;

   localparam int COLS   = 80;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int LB_AW  = 7;

   logic              pix_clk = 1'b0;
   logic              rst = 1'b1;
   logic [11:0]       H_count = 12'd0;
   logic [11:0]       V_count = 12'd0;
   logic              wr_valid = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              lb_we;
   logic [LB_AW-1:0]  lb_addr;
   logic [DATA_W-1:0] lb_data;
   logic              busy;
   logic              overrun;

   int vectors = 0;
   int miscompares = 0;

   // Reference contents (bench knowledge) and the VRAM model seen by the DUT.
   logic [DATA_W-1:0] ref_mem [0:4095];
   logic [DATA_W-1:0] vram    [0:4095];
   logic              load_mem = 1'b1;

   text_fetch_scheduler dut (
      .pix_clk   (pix_clk),
      .rst       (rst),
      .H_count   (H_count),
      .V_count   (V_count),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .lb_we     (lb_we),
      .lb_addr   (lb_addr),
      .lb_data   (lb_data),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 pix_clk = ~pix_clk;

   always @(posedge pix_clk) begin
      if (load_mem) begin
         for (int i = 0; i < 4096; i++) vram[i] <= ref_mem[i];
      end else if (ram_en) begin
         if (ram_we) vram[ram_addr] <= ram_wdata;
         else        ram_rdata <= vram[ram_addr];
      end
   end

   // Console rules: which row the coming scan line starts, if any.
   function automatic int exp_base(input int v);
      int n;
      n = (v == 524) ? 0 : v + 1;
      if (n < 480 && (n % 16) == 0) return (n / 16) * COLS;
      return -1;
   endfunction

   task automatic tick;
      @(posedge pix_clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset;
      @(negedge pix_clk);
      vectors++;
      if ({busy, overrun, lb_we, ram_en, ram_we, lb_addr, lb_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_state busy=%b ovr=%b lbwe=%b en=%b we=%b lba=%0d lbd=%h, want all 0",
                  busy, overrun, lb_we, ram_en, ram_we, lb_addr, lb_data);
      end
      tick; rst = 1'b0;
      @(negedge pix_clk);
      vectors++;
      if ({wr_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_release wr_ready=%b busy=%b, want 1/0", wr_ready, busy);
      end
      repeat (3) tick;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy, overrun, lb_we, ram_en} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_async busy=%b ovr=%b lbwe=%b en=%b, want 0", busy, overrun, lb_we, ram_en);
      end
      tick; rst = 1'b0;
      @(negedge pix_clk);
      vectors++;
      if (wr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_async_release wr_ready=%b, want 1", wr_ready);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_row0;
      int b;
      b = exp_base(524);
      tick; V_count = 12'd524; H_count = 12'd640;
      @(negedge pix_clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL row0_trigger_cycle busy=%b, want 0", busy);
      end
      for (int k = 0; k <= COLS; k++) begin
         tick; H_count = 12'd0;
         @(negedge pix_clk);
         vectors++;
         if (k < COLS) begin
            if ({ram_en, ram_we, ram_addr, busy, wr_ready} !== {1'b1, 1'b0, 12'(b + k), 1'b1, 1'b0}) begin
               miscompares++;
               $display("FAIL row0_read k=%0d en=%b we=%b addr=%0d busy=%b rdy=%b, want 1 0 %0d 1 0",
                        k, ram_en, ram_we, ram_addr, busy, wr_ready, b + k);
            end
         end else if ({ram_en, busy, wr_ready} !== 3'b011) begin
            miscompares++;
            $display("FAIL row0_drain en=%b busy=%b rdy=%b, want 0 1 1", ram_en, busy, wr_ready);
         end
         vectors++;
         if (k == 0) begin
            if (lb_we !== 1'b0) begin
               miscompares++;
               $display("FAIL row0_lb_early lb_we=%b, want 0", lb_we);
            end
         end else if ({lb_we, lb_addr, lb_data} !== {1'b1, 7'(k - 1), ref_mem[b + k - 1]}) begin
            miscompares++;
            $display("FAIL row0_lb k=%0d we=%b addr=%0d data=%h, want 1 %0d %h",
                     k, lb_we, lb_addr, lb_data, k - 1, ref_mem[b + k - 1]);
         end
      end
      tick;
      @(negedge pix_clk);
      vectors++;
      if ({busy, lb_we, ram_en} !== 3'b000) begin
         miscompares++;
         $display("FAIL row0_end busy=%b lbwe=%b en=%b, want 0", busy, lb_we, ram_en);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_contention;
      tick; V_count = 12'd524; H_count = 12'd640;
      for (int k = 0; k <= COLS; k++) begin
         tick; H_count = 12'd0;
         if (k == 0) begin
            wr_valid = 1'b1; wr_addr = 12'h123; wr_data = 16'hABCD;
         end
         @(negedge pix_clk);
         vectors++;
         if (k < COLS) begin
            if ({wr_ready, ram_we, ram_addr} !== {1'b0, 1'b0, 12'(k)}) begin
               miscompares++;
               $display("FAIL cont_fetch k=%0d rdy=%b we=%b addr=%0d, want 0 0 %0d",
                        k, wr_ready, ram_we, ram_addr, k);
            end
         end else if ({wr_ready, ram_en, ram_we, ram_addr, ram_wdata} !==
                      {1'b1, 1'b1, 1'b1, 12'h123, 16'hABCD}) begin
            miscompares++;
            $display("FAIL cont_write rdy=%b en=%b we=%b addr=%h wdata=%h, want 1 1 1 123 abcd",
                     wr_ready, ram_en, ram_we, ram_addr, ram_wdata);
         end
         if (k > 0) begin
            vectors++;
            if ({lb_we, lb_addr, lb_data} !== {1'b1, 7'(k - 1), ref_mem[k - 1]}) begin
               miscompares++;
               $display("FAIL cont_lb k=%0d we=%b addr=%0d data=%h, want 1 %0d %h",
                        k, lb_we, lb_addr, lb_data, k - 1, ref_mem[k - 1]);
            end
         end
      end
      ref_mem[12'h123] = 16'hABCD;
      tick; wr_valid = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_writer;
      logic             v;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      for (int i = 0; i < 24; i++) begin
         tick;
         v = 1'($urandom_range(0, 1));
         a = 12'($urandom_range(0, 479));
         d = 16'($urandom);
         wr_valid = v; wr_addr = a; wr_data = d;
         @(negedge pix_clk);
         vectors++;
         if (v) begin
            if ({wr_ready, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, a, d}) begin
               miscompares++;
               $display("FAIL writer_grant rdy=%b en=%b we=%b addr=%h wd=%h, want 1 1 1 %h %h",
                        wr_ready, ram_en, ram_we, ram_addr, ram_wdata, a, d);
            end
            ref_mem[a] = d;
         end else if ({wr_ready, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, 1'b0, 12'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL writer_idle rdy=%b en=%b we=%b addr=%h wd=%h, want 1 0 0 0 0",
                     wr_ready, ram_en, ram_we, ram_addr, ram_wdata);
         end
      end
      tick; wr_valid = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_row_select;
      int vlist [10];
      int b;
      vlist = '{15, 16, 479, 47, 524, 79, 63, 0, 0, 0};
      vlist[7] = int'($urandom_range(0, 5)) * 16 - 1;
      if (vlist[7] < 0) vlist[7] = 524;
      vlist[8] = int'($urandom_range(0, 524));
      vlist[9] = int'($urandom_range(0, 524));
      foreach (vlist[j]) begin
         b = exp_base(vlist[j]);
         tick; V_count = 12'(vlist[j]); H_count = 12'd640;
         if (b < 0) begin
            for (int k = 0; k < 6; k++) begin
               tick; H_count = 12'd0;
               @(negedge pix_clk);
               vectors++;
               if ({busy, ram_en, lb_we} !== 3'b000) begin
                  miscompares++;
                  $display("FAIL sel_none v=%0d busy=%b en=%b lbwe=%b, want 0", vlist[j], busy, ram_en, lb_we);
               end
            end
         end else begin
            for (int k = 0; k <= COLS; k++) begin
               tick; H_count = 12'd0;
               @(negedge pix_clk);
               if (k < COLS) begin
                  vectors++;
                  if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'(b + k)}) begin
                     miscompares++;
                     $display("FAIL sel_read v=%0d k=%0d en=%b we=%b addr=%0d, want addr %0d",
                              vlist[j], k, ram_en, ram_we, ram_addr, b + k);
                  end
               end
               if (k > 0) begin
                  vectors++;
                  if ({lb_we, lb_addr, lb_data} !== {1'b1, 7'(k - 1), ref_mem[b + k - 1]}) begin
                     miscompares++;
                     $display("FAIL sel_lb v=%0d k=%0d we=%b addr=%0d data=%h, want %0d %h",
                              vlist[j], k, lb_we, lb_addr, lb_data, k - 1, ref_mem[b + k - 1]);
                  end
               end
            end
            vectors++;
            if (overrun !== 1'b0) begin
               miscompares++;
               $display("FAIL sel_overrun v=%0d overrun=%b, want 0", vlist[j], overrun);
            end
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_overrun;
      tick; V_count = 12'd524; H_count = 12'd640;
      for (int k = 0; k <= COLS; k++) begin
         tick; H_count = (k == 39) ? 12'd640 : 12'd0;
         @(negedge pix_clk);
         vectors++;
         if (overrun !== (k >= 40)) begin
            miscompares++;
            $display("FAIL ovr_flag k=%0d overrun=%b, want %b", k, overrun, k >= 40);
         end
         if (k < COLS) begin
            vectors++;
            if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'(k)}) begin
               miscompares++;
               $display("FAIL ovr_read k=%0d en=%b we=%b addr=%0d, want addr %0d",
                        k, ram_en, ram_we, ram_addr, k);
            end
         end
      end
      for (int k = 0; k < 12; k++) begin
         tick;
         @(negedge pix_clk);
         vectors++;
         if ({busy, ram_en, overrun} !== 3'b001) begin
            miscompares++;
            $display("FAIL ovr_after k=%0d busy=%b en=%b overrun=%b, want 0 0 1", k, busy, ram_en, overrun);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_fetch;
      int b;
      tick; V_count = 12'd15; H_count = 12'd640;
      for (int k = 0; k <= 40; k++) begin
         tick; H_count = 12'd0;
         if (k == 40) begin
            #2 rst = 1'b1;
            #1;
            vectors++;
            if ({lb_we, ram_en, busy, overrun, lb_addr, lb_data} !== '0) begin
               miscompares++;
               $display("FAIL rstmid_async lbwe=%b en=%b busy=%b ovr=%b lba=%0d lbd=%h, want 0",
                        lb_we, ram_en, busy, overrun, lb_addr, lb_data);
            end
         end else begin
            @(negedge pix_clk);
            vectors++;
            if (ram_addr !== 12'(80 + k)) begin
               miscompares++;
               $display("FAIL rstmid_read k=%0d addr=%0d, want %0d", k, ram_addr, 80 + k);
            end
         end
      end
      @(negedge pix_clk);
      tick; rst = 1'b0;
      @(negedge pix_clk);
      vectors++;
      if ({wr_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL rstmid_release rdy=%b busy=%b, want 1 0", wr_ready, busy);
      end
      b = exp_base(31);
      tick; V_count = 12'd31; H_count = 12'd640;
      for (int k = 0; k <= COLS; k++) begin
         tick; H_count = 12'd0;
         @(negedge pix_clk);
         if (k < COLS) begin
            vectors++;
            if ({ram_en, ram_we, ram_addr, overrun} !== {1'b1, 1'b0, 12'(b + k), 1'b0}) begin
               miscompares++;
               $display("FAIL rstmid_read2 k=%0d en=%b we=%b addr=%0d ovr=%b, want addr %0d ovr 0",
                        k, ram_en, ram_we, ram_addr, overrun, b + k);
            end
         end
         if (k > 0) begin
            vectors++;
            if ({lb_we, lb_addr, lb_data} !== {1'b1, 7'(k - 1), ref_mem[b + k - 1]}) begin
               miscompares++;
               $display("FAIL rstmid_lb k=%0d we=%b addr=%0d data=%h, want %0d %h",
                        k, lb_we, lb_addr, lb_data, k - 1, ref_mem[b + k - 1]);
            end
         end
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 16'($urandom);
      tick;
      tick;
      load_mem = 1'b0;
      test_reset;
      test_row0;
      test_contention;
      test_writer;
      test_row_select;
      test_overrun;
      test_reset_mid_fetch;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/text_fetch_scheduler.md
Name: text_fetch_scheduler

Overview:
- Sequences the single-port text VRAM for the VGA console, shared between the display line fetch and a write requester such as the CPU or console writer.
- Takes H_count/V_count from the sync generator.
- During horizontal blanking before each new text row, it bursts that row's COLS character words from VRAM into the line buffer.
- Grants the VRAM port to the writer in every cycle it is not fetching.

Parameters:
- COLS, 80, characters per text row (words per fetch burst)
- CHAR_H, 16, scan lines per character row; power of 2
- ADDR_W, 12, VRAM address width; ROWS*COLS <= 2^ADDR_W
- DATA_W, 16, VRAM word width (char code + attribute)
- LB_AW, 7, line-buffer address width; 2^LB_AW >= COLS
- H_FETCH, 640, H_count value that triggers a fetch (first blanking pixel)
- V_ACTIVE_LINES, 480, number of active scan lines (lines 0..V_ACTIVE_LINES-1)
- V_TOTAL, 525, total lines per frame; V_count wraps V_TOTAL-1 -> 0

Ports:
- pix_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- H_count  in  12  horizontal position from sync generator
- V_count  in  12  vertical position from sync generator
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  writer VRAM address
- wr_data  in  DATA_W  writer data
- wr_ready  out  1  writer grant; transfer occurs when wr_valid & wr_ready
- ram_en  out  1  VRAM access enable
- ram_we  out  1  VRAM write enable
- ram_addr  out  ADDR_W  VRAM address
- ram_wdata  out  DATA_W  VRAM write data
- ram_rdata  in  DATA_W  VRAM read data, valid 1 cycle after a read (ram_en & !ram_we)
- lb_we  out  1  line-buffer write strobe
- lb_addr  out  LB_AW  line-buffer column
- lb_data  out  DATA_W  line-buffer data
- busy  out  1  high while state != IDLE
- overrun  out  1  sticky; a trigger arrived while in FETCH

Behaviour:
- Next line: n = (V_count == V_TOTAL-1) ? 0 : V_count+1.
- trigger = (H_count == H_FETCH) & (n < V_ACTIVE_LINES) & (n mod CHAR_H == 0).
- Text row: row = n / CHAR_H. Base address: base = row*COLS, computed at ADDR_W bits and latched on an accepted trigger.
- FSM states are IDLE, FETCH, DRAIN. Column counter idx has LB_AW bits.
- IDLE: on trigger, latch base, set idx=0, go to FETCH next cycle.
- FETCH: each cycle drive ram_en=1, ram_we=0, ram_addr=base+idx, then idx++. After the cycle with idx==COLS-1, go to DRAIN.
- DRAIN: one cycle for the final read data, then IDLE. A trigger in DRAIN is accepted: go to FETCH, latch the new base, idx=0.
- Line-buffer pipeline: one cycle after each read issue, lb_we=1, lb_addr = idx of that read (registered copy), lb_data = ram_rdata. This runs independently of the state, so the last word is still written during DRAIN or a following FETCH. Total burst: reads in cycles T+1..T+COLS; lb_we in cycles T+2..T+COLS+1 (T = trigger cycle).
- Writer:
  - wr_ready = (state != FETCH), combinational.
  - On wr_valid & wr_ready, in the same cycle: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - No writer buffering; the writer holds its request until granted.
- Idle port: outside FETCH with no writer transfer, ram_en=0, ram_we=0. ram_addr and ram_wdata are don't-care, but are driven to 0.
- Overrun: a trigger while in FETCH sets overrun=1, which holds until rst. The trigger is ignored and the current burst completes unchanged.
- Reset (asynchronous, at any time including mid-burst):
  - state=IDLE, idx=0, base=0, overrun=0, lb pipeline cleared.
  - Outputs after reset: lb_we=0, lb_addr=0, lb_data=0, busy=0, ram_en=0, ram_we=0.
  - wr_ready=1 once rst deasserts (state is IDLE).
  - The next trigger restarts a full burst from idx 0.
- Width rules:
  - base+idx never exceeds ROWS*COLS-1; no wrap handling required.
  - idx compares against COLS-1 exactly.

Test Plan:
- Reset: assert rst mid-simulation with wr_valid=0 -> busy=0, overrun=0, lb_we=0, ram_en=0 immediately (asynchronously); wr_ready=1 after rst falls.
- Row 0 fetch: V_count=524, H_count=640 at cycle T -> ram_addr 0..79 with ram_we=0 in cycles T+1..T+80; lb_we in T+2..T+81 with lb_addr 0..79 and lb_data = ram model data; busy high T+1..T+81.
- Row selection: V_count=15, H_count=640 -> reads 80..159. V_count=16 or V_count=479, H_count=640 -> no burst, busy stays 0.
- Contention: wr_valid=1, wr_addr=0x123, wr_data=0xABCD held from T -> wr_ready=0 during FETCH; write issued at T+81 (DRAIN) with ram_we=1, ram_addr=0x123, ram_wdata=0xABCD; no read lost, all 80 lb writes present.
- Overrun: bench drives a second trigger at T+40 -> overrun=1 and stays 1; burst still reads addresses 0..79 in order; no second burst.
- Reset mid-fetch: rst pulse at idx=40 -> lb_we=0, ram_en=0 at once; next trigger on V_count=31 reads 160..239 starting from lb_addr 0; overrun=0.
